// File: rtl/eth_mdio_phy.sv
// eth_mdio_phy: Clause 22 MDIO responder running in the MDC domain.
// It decodes the management frames that the station sends, answers reads
// from a small PHY register set, and captures writes into that set.
module eth_mdio_phy #(
  parameter logic [4:0]  pPhy_Addr = 5'd1,
  parameter logic [15:0] pPhy_Id1  = 16'h0007,
  parameter logic [15:0] pPhy_Id2  = 16'hC0F1,
  parameter int unsigned pPre_Len  = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MDIO_In,
  output logic        MDIO_Out,
  output logic        MDIO_Oe,
  output logic        Reg_Wr_Valid,
  output logic [4:0]  Reg_Wr_Addr,
  output logic [15:0] Reg_Wr_Data,
  output logic        Frame_Err
);

  localparam logic [5:0]  PRE_LEN    = 6'(pPre_Len);
  localparam logic [15:0] BMCR_RESET = 16'h3100;
  localparam logic [15:0] BMSR_VALUE = 16'h7809;
  localparam logic [15:0] ANAR_RESET = 16'h01E1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST2,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_RD_DATA,
    S_WR_DATA,
    S_SKIP
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic        op_hi_q, op_hi_d;
  logic        is_rd_q, is_rd_d;
  logic [4:0]  phyad_q, phyad_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] sh_q, sh_d;
  logic        mdio_out_q, mdio_out_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic        wr_valid_q, wr_valid_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] bmcr_q, bmcr_d;
  logic [15:0] anar_q, anar_d;
  logic [15:0] reg31_q, reg31_d;
  logic [15:0] rd_val;
  logic [15:0] wr_word;

  assign MDIO_Out     = mdio_out_q;
  assign MDIO_Oe      = mdio_oe_q;
  assign Reg_Wr_Valid = wr_valid_q;
  assign Reg_Wr_Addr  = wr_addr_q;
  assign Reg_Wr_Data  = wr_data_q;
  assign Frame_Err    = frame_err_q;

  // Read mux over the register set; BMCR bit 15 (self-clearing reset) always reads 0.
  always_comb begin
    rd_val = 16'h0000;
    case (regad_q)
      5'd0:    rd_val = {1'b0, bmcr_q[14:0]};
      5'd1:    rd_val = BMSR_VALUE;
      5'd2:    rd_val = pPhy_Id1;
      5'd3:    rd_val = pPhy_Id2;
      5'd4:    rd_val = anar_q;
      5'd31:   rd_val = reg31_q;
      default: rd_val = 16'h0000;
    endcase
  end

  // Frame decoder: walks preamble/ST/OP/PHYAD/REGAD/TA/data and computes next outputs and registers.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    op_hi_d     = op_hi_q;
    is_rd_d     = is_rd_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    sh_d        = sh_q;
    mdio_out_d  = mdio_out_q;
    mdio_oe_d   = mdio_oe_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    bmcr_d      = bmcr_q;
    anar_d      = anar_q;
    reg31_d     = reg31_q;
    wr_word     = {sh_q[14:0], MDIO_In};

    case (state_q)
      S_IDLE: begin
        if (MDIO_In) begin
          if (pre_cnt_q < PRE_LEN) pre_cnt_d = pre_cnt_q + 6'd1;
        end else if (pre_cnt_q >= PRE_LEN) begin
          state_d   = S_ST2;
          pre_cnt_d = 6'd0;
          bit_cnt_d = 5'd0;
        end else begin
          pre_cnt_d = 6'd0;
        end
      end

      S_ST2: begin
        bit_cnt_d = 5'd0;
        if (MDIO_In) begin
          state_d = S_OP;
        end else begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end
      end

      S_OP: begin
        if (bit_cnt_q == 5'd0) begin
          op_hi_d   = MDIO_In;
          bit_cnt_d = 5'd1;
        end else begin
          bit_cnt_d = 5'd0;
          if (op_hi_q != MDIO_In) begin
            is_rd_d = op_hi_q;
            state_d = S_PHYAD;
          end else begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
          end
        end
      end

      S_PHYAD: begin
        phyad_d = {phyad_q[3:0], MDIO_In};
        if (bit_cnt_q == 5'd4) begin
          bit_cnt_d = 5'd0;
          state_d   = S_REGAD;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      S_REGAD: begin
        regad_d = {regad_q[3:0], MDIO_In};
        if (bit_cnt_q == 5'd4) begin
          bit_cnt_d = 5'd0;
          state_d   = (phyad_q == pPhy_Addr) ? S_TA : S_SKIP;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      S_TA: begin
        if (bit_cnt_q == 5'd0) begin
          bit_cnt_d = 5'd1;
          if (is_rd_q) begin
            mdio_oe_d  = 1'b1;
            mdio_out_d = 1'b0;
            sh_d       = rd_val;
          end
        end else begin
          bit_cnt_d = 5'd0;
          if (is_rd_q) begin
            state_d    = S_RD_DATA;
            mdio_out_d = sh_q[15];
            sh_d       = {sh_q[14:0], 1'b0};
          end else begin
            state_d = S_WR_DATA;
          end
        end
      end

      S_RD_DATA: begin
        if (bit_cnt_q == 5'd15) begin
          mdio_oe_d  = 1'b0;
          mdio_out_d = 1'b1;
          bit_cnt_d  = 5'd0;
          state_d    = S_IDLE;
        end else begin
          mdio_out_d = sh_q[15];
          sh_d       = {sh_q[14:0], 1'b0};
          bit_cnt_d  = bit_cnt_q + 5'd1;
        end
      end

      S_WR_DATA: begin
        sh_d = wr_word;
        if (bit_cnt_q == 5'd15) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = regad_q;
          wr_data_d  = wr_word;
          bit_cnt_d  = 5'd0;
          state_d    = S_IDLE;
          case (regad_q)
            5'd0: begin
              if (wr_word[15]) begin
                bmcr_d  = BMCR_RESET;
                anar_d  = ANAR_RESET;
                reg31_d = 16'h0000;
              end else begin
                bmcr_d = {1'b0, wr_word[14:0]};
              end
            end
            5'd4:    anar_d  = wr_word;
            5'd31:   reg31_d = wr_word;
            default: ;
          endcase
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      S_SKIP: begin
        if (bit_cnt_q == 5'd17) begin
          bit_cnt_d = 5'd0;
          state_d   = S_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = 5'd0;
        pre_cnt_d = 6'd0;
      end
    endcase
  end

  // State and register update; reset drops any frame in flight and restores the register set.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 5'd0;
      pre_cnt_q   <= 6'd0;
      op_hi_q     <= 1'b0;
      is_rd_q     <= 1'b0;
      phyad_q     <= 5'd0;
      regad_q     <= 5'd0;
      sh_q        <= 16'h0000;
      mdio_out_q  <= 1'b1;
      mdio_oe_q   <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 16'h0000;
      frame_err_q <= 1'b0;
      bmcr_q      <= BMCR_RESET;
      anar_q      <= ANAR_RESET;
      reg31_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      op_hi_q     <= op_hi_d;
      is_rd_q     <= is_rd_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      sh_q        <= sh_d;
      mdio_out_q  <= mdio_out_d;
      mdio_oe_q   <= mdio_oe_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      bmcr_q      <= bmcr_d;
      anar_q      <= anar_d;
      reg31_q     <= reg31_d;
    end
  end

endmodule

// File: tb/tb_eth_mdio_phy.sv
// tb_eth_mdio_phy: directed frames from an MDIO station model against eth_mdio_phy.
module tb_eth_mdio_phy;

  logic        Clk;
  logic        Rst;
  logic        mdioM;
  logic        MDIO_In;
  logic        MDIO_Out;
  logic        MDIO_Oe;
  logic        Reg_Wr_Valid;
  logic [4:0]  Reg_Wr_Addr;
  logic [15:0] Reg_Wr_Data;
  logic        Frame_Err;

  int checks = 0;
  int fails  = 0;

  logic [15:0] rdData;
  logic        ta2;
  logic        relOut;
  logic        abortOe;
  int          oeBad;
  int          validCnt;
  int          errCnt;

  assign MDIO_In = MDIO_Oe ? MDIO_Out : mdioM;

  eth_mdio_phy dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .MDIO_In      (MDIO_In),
    .MDIO_Out     (MDIO_Out),
    .MDIO_Oe      (MDIO_Oe),
    .Reg_Wr_Valid (Reg_Wr_Valid),
    .Reg_Wr_Addr  (Reg_Wr_Addr),
    .Reg_Wr_Data  (Reg_Wr_Data),
    .Frame_Err    (Frame_Err)
  );

  // Free-running MDC.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One station frame: preLen ones, then ST/OP/PHYAD/REGAD/TA/data. Bit n is the last REGAD bit.
  task automatic applyStimulus(input int preLen, input logic [1:0] st, input logic [1:0] op,
                               input logic [4:0] phy, input logic [4:0] regAddr,
                               input logic [15:0] wdata, input bit expDrive, input int abortAt,
                               output logic [15:0] rdOut, output logic ta2Out,
                               output logic relOutBit, output int oeBadCnt,
                               output int validCount, output int errCount,
                               output logic abortOeOut);
    logic [31:0] body;
    logic        b;
    logic        expOe;
    int          n;
    n          = preLen + 13;
    body       = (op == 2'b01) ? {st, op, phy, regAddr, 2'b10, wdata}
                               : {st, op, phy, regAddr, 2'b11, 16'hFFFF};
    rdOut      = 16'hxxxx;
    ta2Out     = 1'bx;
    relOutBit  = 1'bx;
    abortOeOut = 1'bx;
    oeBadCnt   = 0;
    validCount = 0;
    errCount   = 0;
    for (int i = 0; i < preLen + 32; i++) begin
      b = (i < preLen) ? 1'b1 : body[31 - (i - preLen)];
      @(negedge Clk);
      mdioM = b;
      if (i == abortAt) Rst = 1'b1;
      @(posedge Clk);
      #1;
      if (i == abortAt) begin
        abortOeOut = MDIO_Oe;
        Rst = 1'b0;
        break;
      end
      if (Reg_Wr_Valid) validCount++;
      if (Frame_Err) errCount++;
      expOe = expDrive && (i >= n + 1) && (i <= n + 17);
      if (MDIO_Oe !== expOe) oeBadCnt++;
      if (i == n + 1) ta2Out = MDIO_Out;
      if (i >= n + 2 && i <= n + 17) rdOut[15 - (i - n - 2)] = MDIO_Out;
      if (i == n + 18) relOutBit = MDIO_Out;
    end
  endtask

  // Directed sequence of frames with hand-computed expectations.
  initial begin
    Rst   = 1'b1;
    mdioM = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset_oe",    32'(MDIO_Oe),      32'd0);
    checkOutput("reset_out",   32'(MDIO_Out),     32'd1);
    checkOutput("reset_valid", 32'(Reg_Wr_Valid), 32'd0);
    checkOutput("reset_addr",  32'(Reg_Wr_Addr),  32'd0);
    checkOutput("reset_data",  32'(Reg_Wr_Data),  32'd0);
    checkOutput("reset_err",   32'(Frame_Err),    32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    $display("[TB] read reg 2 from PHY 1");
    applyStimulus(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 1'b1, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("rd2_data",   32'(rdData), 32'h0007);
    checkOutput("rd2_ta2",    32'(ta2),    32'd0);
    checkOutput("rd2_oe",     32'(oeBad),  32'd0);
    checkOutput("rd2_relout", 32'(relOut), 32'd1);

    $display("[TB] write 0xABCD to reg 4, read back");
    applyStimulus(32, 2'b01, 2'b01, 5'd1, 5'd4, 16'hABCD, 1'b0, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("wr4_valid", 32'(validCnt),    32'd1);
    checkOutput("wr4_addr",  32'(Reg_Wr_Addr), 32'd4);
    checkOutput("wr4_data",  32'(Reg_Wr_Data), 32'hABCD);
    checkOutput("wr4_oe",    32'(oeBad),       32'd0);
    applyStimulus(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0000, 1'b1, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("rd4_data", 32'(rdData), 32'hABCD);

    $display("[TB] BMCR soft reset");
    applyStimulus(32, 2'b01, 2'b01, 5'd1, 5'd0, 16'h8000, 1'b0, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("wr0_valid", 32'(validCnt), 32'd1);
    applyStimulus(32, 2'b01, 2'b10, 5'd1, 5'd0, 16'h0000, 1'b1, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("rd0_after_sreset", 32'(rdData), 32'h3100);
    applyStimulus(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0000, 1'b1, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("rd4_after_sreset", 32'(rdData), 32'h01E1);

    $display("[TB] other PHY address, then PHY 1");
    applyStimulus(32, 2'b01, 2'b10, 5'd5, 5'd1, 16'h0000, 1'b0, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("phy5_oe", 32'(oeBad), 32'd0);
    applyStimulus(32, 2'b01, 2'b10, 5'd1, 5'd1, 16'h0000, 1'b1, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("rd1_data", 32'(rdData), 32'h7809);
    checkOutput("rd1_oe",   32'(oeBad),  32'd0);

    $display("[TB] short preamble and bad frames");
    applyStimulus(31, 2'b01, 2'b10, 5'd1, 5'd1, 16'h0000, 1'b0, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("pre31_oe",  32'(oeBad),  32'd0);
    checkOutput("pre31_err", 32'(errCnt), 32'd0);
    applyStimulus(32, 2'b01, 2'b11, 5'd1, 5'd1, 16'h0000, 1'b0, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("op11_err", 32'(errCnt), 32'd1);
    checkOutput("op11_oe",  32'(oeBad),  32'd0);
    applyStimulus(32, 2'b00, 2'b10, 5'd1, 5'd1, 16'h0000, 1'b0, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("st00_err", 32'(errCnt), 32'd1);

    $display("[TB] reg 31 and read-only write");
    applyStimulus(32, 2'b01, 2'b01, 5'd1, 5'd31, 16'h1234, 1'b0, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("wr31_addr", 32'(Reg_Wr_Addr), 32'd31);
    applyStimulus(32, 2'b01, 2'b01, 5'd1, 5'd1, 16'h5555, 1'b0, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("wr1_valid", 32'(validCnt),    32'd1);
    checkOutput("wr1_data",  32'(Reg_Wr_Data), 32'h5555);
    applyStimulus(32, 2'b01, 2'b10, 5'd1, 5'd31, 16'h0000, 1'b1, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("rd31_data", 32'(rdData), 32'h1234);
    applyStimulus(32, 2'b01, 2'b10, 5'd1, 5'd1, 16'h0000, 1'b1, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("rd1_after_wr", 32'(rdData), 32'h7809);

    $display("[TB] reset during read data");
    applyStimulus(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 1'b1, 32 + 13 + 6,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("abort_oe", 32'(abortOe), 32'd0);
    applyStimulus(32, 2'b01, 2'b10, 5'd1, 5'd3, 16'h0000, 1'b1, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("rd3_data", 32'(rdData), 32'hC0F1);
    checkOutput("rd3_oe",   32'(oeBad),  32'd0);
    applyStimulus(32, 2'b01, 2'b10, 5'd1, 5'd31, 16'h0000, 1'b1, -1,
                  rdData, ta2, relOut, oeBad, validCnt, errCnt, abortOe);
    checkOutput("rd31_after_rst", 32'(rdData), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
